// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] NOP = 32'h00000013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - read-first FIFO of fetched {instruction, pc} entries
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               push_i,
    input  fetch_entry_t       entry_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output fetch_entry_t       head_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               empty_o,
    output logic               full_o
);

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == CNT_W'(DEPTH));
    assign count_o = count;
    assign head_o  = mem[rd_ptr];

    // A pop frees the slot in the same cycle, so push-on-full is legal alongside a pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= entry_i;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC/fetch FSM, credit-based issue and decode handoff; FETCH_PERF_COUNTERS_EN adds perf counters
module instruction_fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0,
    parameter int          BUFFER_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        fetch_o,
    output logic        invalidate_o,
    output logic [31:0] address_o,
    input  logic [31:0] instruction_i,
    input  logic        valid_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    input  logic        halt_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] fetched_count_o,
    output logic [31:0] squashed_count_o
`endif
);

    localparam int CNT_W = $clog2(BUFFER_DEPTH) + 1;

    fetch_state_t      state;
    logic [31:0]       pc;
    logic              inflight;
    logic [31:0]       inflight_pc;
    logic [CNT_W-1:0]  buf_count;
    logic              buf_empty;
    logic              buf_full;
    logic              buf_push;
    logic              pop;
    logic              credit;
    logic [CNT_W:0]    occupancy;
    fetch_entry_t      head;
    fetch_entry_t      resp_entry;

    assign instr_valid_o = ~buf_empty;
    assign instr_o       = head.instruction;
    assign instr_pc_o    = head.pc;
    assign pop           = instr_valid_o & instr_ready_i;

    // Reserve a slot for every outstanding response so a push can never overflow.
    assign occupancy = {1'b0, buf_count} - (CNT_W+1)'(pop) + (CNT_W+1)'(inflight);
    assign credit    = occupancy < (CNT_W+1)'(BUFFER_DEPTH);

    assign fetch_o      = (state == FETCH) & ~halt_i & credit;
    assign invalidate_o = redirect_i & fetch_o;
    assign address_o    = pc;

    assign buf_push               = valid_i & inflight & ~redirect_i;
    assign resp_entry.instruction = instruction_i;
    assign resp_entry.pc          = inflight_pc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= BOOT;
            pc          <= BOOT_ADDRESS;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            case (state)
                BOOT:    state <= FETCH;
                FETCH:   if (halt_i)  state <= HALTED;
                HALTED:  if (!halt_i) state <= FETCH;
                default: state <= BOOT;
            endcase

            if (redirect_i) begin
                pc <= word_align(target_i);
            end else if (fetch_o) begin
                pc <= pc + 32'd4;
            end

            inflight    <= fetch_o & ~redirect_i;
            inflight_pc <= pc;
        end
    end

    fetch_buffer #(
        .DEPTH (BUFFER_DEPTH)
    ) u_fetch_buffer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (buf_push),
        .entry_i (resp_entry),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .head_o  (head),
        .count_o (buf_count),
        .empty_o (buf_empty),
        .full_o  (buf_full)
    );

    overflow_guard: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(buf_push && buf_full && !pop));

`ifdef FETCH_PERF_COUNTERS_EN
    logic dropped;
    assign dropped = valid_i & inflight & redirect_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetched_count_o  <= '0;
            squashed_count_o <= '0;
        end else begin
            fetched_count_o  <= fetched_count_o + 32'(buf_push);
            squashed_count_o <= squashed_count_o + 32'(invalidate_o) + 32'(dropped);
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        fetch_o;
    logic        invalidate_o;
    logic [31:0] address_o;
    logic [31:0] instruction_i;
    logic        valid_i;
    logic        redirect_i;
    logic [31:0] target_i;
    logic        halt_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetched_count_o;
    logic [31:0] squashed_count_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    instruction_fetch_unit #(
        .BOOT_ADDRESS (32'h0),
        .BUFFER_DEPTH (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .fetch_o       (fetch_o),
        .invalidate_o  (invalidate_o),
        .address_o     (address_o),
        .instruction_i (instruction_i),
        .valid_i       (valid_i),
        .redirect_i    (redirect_i),
        .target_i      (target_i),
        .halt_i        (halt_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .fetched_count_o  (fetched_count_o),
        .squashed_count_o (squashed_count_o)
`endif
    );

    // Memory: answers every request one cycle later with a NOP, squashed or not.
    always @(posedge clk_i) begin
        valid_i       <= fetch_o;
        instruction_i <= fetch_o ? NOP : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n_i    = 1'b0;
        redirect_i = 1'b0;
        halt_i     = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
    endtask

    initial begin
        rst_n_i       = 1'b0;
        redirect_i    = 1'b0;
        target_i      = 32'h0;
        halt_i        = 1'b0;
        instr_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_fetch", 32'(fetch_o), 32'd0);
        check("rst_inval", 32'(invalidate_o), 32'd0);
        check("rst_ivalid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_ipc", instr_pc_o, 32'h0);
        check("rst_addr", address_o, 32'h0);

        // 1: streaming with decode always ready
        do_reset();
        check("t1_boot_fetch", 32'(fetch_o), 32'd0);
        tick();
        check("t1_fetch0", 32'(fetch_o), 32'd1);
        check("t1_addr0", address_o, 32'h0);
        tick();
        check("t1_addr4", address_o, 32'h4);
        check("t1_ivalid_early", 32'(instr_valid_o), 32'd0);
        tick();
        check("t1_addr8", address_o, 32'h8);
        check("t1_ivalid", 32'(instr_valid_o), 32'd1);
        check("t1_pc0", instr_pc_o, 32'h0);
        check("t1_instr", instr_o, 32'h13);
        tick();
        check("t1_pc4", instr_pc_o, 32'h4);
        check("t1_addrc", address_o, 32'hC);
        tick();
        check("t1_pc8", instr_pc_o, 32'h8);

        // 2: decode stalled, credit limits issue to buffer depth
        instr_ready_i = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_fetch", 32'(fetch_o), 32'd1);
            check("t2_addr", address_o, 32'(k * 4));
        end
        tick();
        check("t2_stop", 32'(fetch_o), 32'd0);
        check("t2_addr10", address_o, 32'h10);
        tick();
        check("t2_stop2", 32'(fetch_o), 32'd0);
        check("t2_ivalid", 32'(instr_valid_o), 32'd1);
        check("t2_pc0", instr_pc_o, 32'h0);
        instr_ready_i = 1'b1;
        #1;
        check("t2_resume", 32'(fetch_o), 32'd1);
        check("t2_resume_addr", address_o, 32'h10);
        tick();
        check("t2_pc4", instr_pc_o, 32'h4);
        tick();
        check("t2_pc8", instr_pc_o, 32'h8);
        tick();
        check("t2_pcc", instr_pc_o, 32'hC);
        tick();
        check("t2_pc10", instr_pc_o, 32'h10);

        // 3: redirect coincident with a response
        do_reset();
        tick();
        tick();
        redirect_i = 1'b1;
        target_i   = 32'h80;
        #1;
        check("t3_inval", 32'(invalidate_o), 32'd1);
        @(posedge clk_i);
        #1;
        redirect_i = 1'b0;
        tick();
        check("t3_ivalid_drop", 32'(instr_valid_o), 32'd0);
        check("t3_addr80", address_o, 32'h80);
        check("t3_fetch", 32'(fetch_o), 32'd1);
        tick();
        check("t3_stray_ignored", 32'(instr_valid_o), 32'd0);
        check("t3_addr84", address_o, 32'h84);
        tick();
        check("t3_ivalid", 32'(instr_valid_o), 32'd1);
        check("t3_pc80", instr_pc_o, 32'h80);

        // 4: redirect squashes the same-cycle fetch, target realigned
        do_reset();
        tick();
        redirect_i = 1'b1;
        target_i   = 32'h102;
        #1;
        check("t4_fetch", 32'(fetch_o), 32'd1);
        check("t4_inval", 32'(invalidate_o), 32'd1);
        @(posedge clk_i);
        #1;
        redirect_i = 1'b0;
        tick();
        check("t4_addr100", address_o, 32'h100);
        check("t4_noinval", 32'(invalidate_o), 32'd0);
        tick();
        check("t4_ivalid_squashed", 32'(instr_valid_o), 32'd0);
        tick();
        check("t4_ivalid", 32'(instr_valid_o), 32'd1);
        check("t4_pc100", instr_pc_o, 32'h100);

        // 5: halt blocks issue, in-flight entry still delivered
        do_reset();
        tick();
        tick();
        halt_i = 1'b1;
        #1;
        check("t5_halt_fetch", 32'(fetch_o), 32'd0);
        tick();
        check("t5_halt_fetch", 32'(fetch_o), 32'd0);
        check("t5_inflight_valid", 32'(instr_valid_o), 32'd1);
        check("t5_inflight_pc", instr_pc_o, 32'h0);
        tick();
        check("t5_drained", 32'(instr_valid_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("t5_halt_fetch", 32'(fetch_o), 32'd0);
            check("t5_held_addr", address_o, 32'h4);
            if (k < 2) tick();
        end
        tick();
        halt_i = 1'b0;
        #1;
        check("t5_still_halted", 32'(fetch_o), 32'd0);
        tick();
        check("t5_resume", 32'(fetch_o), 32'd1);
        check("t5_resume_addr", address_o, 32'h4);

        // 6: asynchronous reset with entries buffered
        instr_ready_i = 1'b0;
        do_reset();
        repeat (5) tick();
        check("t6_ivalid", 32'(instr_valid_o), 32'd1);
        instr_ready_i = 1'b1;
        #1;
        check("t6_fetch", 32'(fetch_o), 32'd1);
        rst_n_i = 1'b0;
        #1;
        check("t6_rst_ivalid", 32'(instr_valid_o), 32'd0);
        check("t6_rst_fetch", 32'(fetch_o), 32'd0);
        check("t6_rst_addr", address_o, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        check("t6_boot", 32'(fetch_o), 32'd0);
        tick();
        check("t6_restart", 32'(fetch_o), 32'd1);
        check("t6_restart_addr", address_o, 32'h0);
        tick();
        check("t6_no_stale", 32'(instr_valid_o), 32'd0);
        tick();
        check("t6_ivalid", 32'(instr_valid_o), 32'd1);
        check("t6_pc0", instr_pc_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
